// File: rtl/uart_tx_frame_gen_if.sv
// Byte-push handshake between the bus side and the UART TX frame generator.
// A push happens on a clock edge where wr_valid and wr_ready are both high.
interface uart_tx_frame_gen_if;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;

    modport master (
        output wr_data,
        output wr_valid,
        input  wr_ready
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        output wr_ready
    );
endinterface

// File: rtl/uart_tx_frame_gen.sv
// UART TX frame generator: byte FIFO, 11-bit frame builder and send/tx_active handshake FSM.
// Optional feature macro: UART_TXFG_LEVEL_EN adds fifo_level and tx_irq outputs.
module uart_tx_frame_gen #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_frame_gen_if.slave  wr_if,
    input  logic                flush,
    input  logic [1:0]          parity_type,
    input  logic                stop_bits,
    input  logic                data_length,
    input  logic                tx_active,
    output logic [10:0]         frame_out,
    output logic                send,
    output logic                busy,
    output logic                fifo_empty,
    output logic                fifo_full
`ifdef UART_TXFG_LEVEL_EN
    ,
    output logic [ADDR_W:0]     fifo_level,
    output logic                tx_irq
`endif
);

    localparam int CW = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT
    } state_t;

    state_t             r_state_reg;
    state_t             w_state_next;

    logic [7:0]         r_mem [0:FIFO_DEPTH-1];
    logic [7:0]         r_rd_data_reg;
    logic [ADDR_W-1:0]  r_wr_ptr_reg;
    logic [ADDR_W-1:0]  r_rd_ptr_reg;
    logic [CW-1:0]      r_count_reg;
    logic [CW-1:0]      w_count_next;
    logic               w_push;
    logic               w_pop;

    logic               r_act_meta_reg;
    logic               r_act_s_reg;

    logic [10:0]        r_frame_reg;
    logic [10:0]        w_frame;
    logic [7:0]         w_data_field;
    logic               w_par_en;
    logic               w_par_bit;
    logic [3:0]         w_stop_pos;

    logic               r_send_reg;
    logic               w_send_next;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    assign fifo_empty     = (r_count_reg == '0);
    assign fifo_full      = (r_count_reg == CW'(FIFO_DEPTH));
    assign wr_if.wr_ready = ~fifo_full;

    // flush wins over both push and pop so the FIFO ends up truly empty
    assign w_push = wr_if.wr_valid & ~fifo_full & ~flush;
    assign w_pop  = (r_state_reg == S_LOAD) & ~fifo_empty & ~flush;

    always_comb begin
        w_count_next = r_count_reg;
        if (flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count_reg + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_reg <= '0;
            r_rd_ptr_reg <= '0;
            r_count_reg  <= '0;
        end else begin
            r_count_reg <= w_count_next;
            if (flush) begin
                r_wr_ptr_reg <= '0;
                r_rd_ptr_reg <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr_reg <= r_wr_ptr_reg + ADDR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr_reg <= r_rd_ptr_reg + ADDR_W'(1);
                end
            end
        end
    end

    // Head is read every cycle; IDLE always precedes LOAD, so the sample is current by LOAD.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr_reg] <= wr_if.wr_data;
        end
        r_rd_data_reg <= r_mem[r_rd_ptr_reg];
    end

    // ------------------------------------------------------------------
    // tx_active synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_meta_reg <= 1'b0;
            r_act_s_reg    <= 1'b0;
        end else begin
            r_act_meta_reg <= tx_active;
            r_act_s_reg    <= r_act_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Frame builder
    // ------------------------------------------------------------------
    // Bit 7 is forced to zero in 7-bit mode so it affects neither data nor parity.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_data_field
            if (gi == 7) begin : g_msb
                assign w_data_field[gi] = r_rd_data_reg[gi] & data_length;
            end else begin : g_low
                assign w_data_field[gi] = r_rd_data_reg[gi];
            end
        end
    endgenerate

    assign w_par_en   = (parity_type == 2'b01) || (parity_type == 2'b10);
    assign w_par_bit  = (parity_type == 2'b01) ? ~(^w_data_field) : (^w_data_field);
    assign w_stop_pos = 4'd8 + {3'b000, data_length} + {3'b000, w_par_en};

    // Stop bits and the idle fill above them are both mark; they are written explicitly
    // so the layout reads like the line, even though the values coincide.
    always_comb begin
        w_frame    = '1;
        w_frame[0] = 1'b0;
        if (data_length) begin
            w_frame[8:1] = w_data_field;
            if (w_par_en) begin
                w_frame[9] = w_par_bit;
            end
        end else begin
            w_frame[7:1] = w_data_field[6:0];
            if (w_par_en) begin
                w_frame[8] = w_par_bit;
            end
        end
        w_frame[w_stop_pos] = 1'b1;
        if (stop_bits && (w_stop_pos < 4'd10)) begin
            w_frame[w_stop_pos + 4'd1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_reg <= 11'h7FF;
        end else if (r_state_reg == S_LOAD) begin
            r_frame_reg <= w_frame;
        end
    end

    assign frame_out = r_frame_reg;

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg <= S_IDLE;
            r_send_reg  <= 1'b0;
        end else begin
            r_state_reg <= w_state_next;
            r_send_reg  <= w_send_next;
        end
    end

    always_comb begin
        w_state_next = r_state_reg;
        w_send_next  = 1'b0;
        unique case (r_state_reg)
            S_IDLE: begin
                if (!fifo_empty && !r_act_s_reg) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_next = S_REQ;
            end
            S_REQ: begin
                // send drops on the same edge that moves the FSM into WAIT
                if (r_act_s_reg) begin
                    w_state_next = S_WAIT;
                end else begin
                    w_send_next = 1'b1;
                end
            end
            S_WAIT: begin
                if (!r_act_s_reg) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign send = r_send_reg;
    assign busy = (r_state_reg != S_IDLE);

`ifdef UART_TXFG_LEVEL_EN
    logic r_irq_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_reg <= 1'b0;
        end else begin
            r_irq_reg <= (w_count_next == '0) && (w_state_next == S_IDLE);
        end
    end

    assign fifo_level = r_count_reg;
    assign tx_irq     = r_irq_reg;
`endif

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed bench for uart_tx_frame_gen: scoreboard of expected frames, serializer handshake model.
// Expected frames are pushed when a byte is accepted and popped when send rises.
module tb_uart_tx_frame_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  parity_type;
    logic        stop_bits;
    logic        data_length;
    logic        tx_active;
    logic [10:0] frame_out;
    logic        send;
    logic        busy;
    logic        fifo_empty;
    logic        fifo_full;
`ifdef UART_TXFG_LEVEL_EN
    logic [4:0]  fifo_level;
    logic        tx_irq;
`endif

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [10:0] sb [$];

    always #5 clk = ~clk;

    uart_tx_frame_gen_if wr_if ();

    uart_tx_frame_gen #(
        .FIFO_DEPTH (16),
        .ADDR_W     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_if       (wr_if),
        .flush       (flush),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
        .data_length (data_length),
        .tx_active   (tx_active),
        .frame_out   (frame_out),
        .send        (send),
        .busy        (busy),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full)
`ifdef UART_TXFG_LEVEL_EN
        ,
        .fifo_level  (fifo_level),
        .tx_irq      (tx_irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, then mark to bit 10.
    function automatic logic [10:0] model(input logic [7:0] b, input logic len8, input logic [1:0] pt);
        logic [10:0] f;
        int ones;
        int pp;
        f    = 11'h7FF;
        f[0] = 1'b0;
        if (len8) begin
            f[8:1] = b;
            ones   = $countones(b);
            pp     = 9;
        end else begin
            f[7:1] = b[6:0];
            ones   = $countones(b[6:0]);
            pp     = 8;
        end
        if (pt == 2'b01) f[pp] = (ones % 2 == 0);
        else if (pt == 2'b10) f[pp] = (ones % 2 == 1);
        return f;
    endfunction

    task automatic push(input logic [7:0] b, input logic [10:0] exp);
        logic acc;
        wr_if.wr_data  = b;
        wr_if.wr_valid = 1'b1;
        acc = wr_if.wr_ready && !flush;
        @(posedge clk);
        #1;
        wr_if.wr_valid = 1'b0;
        if (acc) sb.push_back(exp);
    endtask

    task automatic wait_send(input string tag);
        int k;
        k = 0;
        while (send !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_send"}, send, 1);
        check({tag, "_sbq"}, sb.size() > 0, 1);
        if (sb.size() > 0) check({tag, "_frame"}, frame_out, sb.pop_front());
    endtask

    // Serializer model: accept the frame, optionally flush while shifting, then release.
    task automatic ack(input string tag, input bit do_flush);
        int k;
        @(posedge clk);
        #1;
        tx_active = 1'b1;
        k = 0;
        while (send !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_drop"}, send, 0);
        check({tag, "_busyw"}, busy, 1);
        if (do_flush) begin
            check({tag, "_prefl"}, fifo_empty, 0);
            @(posedge clk);
            #1;
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
            sb.delete();
            check({tag, "_flempty"}, fifo_empty, 1);
            check({tag, "_flbusy"}, busy, 1);
        end
        repeat (3) @(posedge clk);
        #1;
        tx_active = 1'b0;
        k = 0;
        while (busy !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw;
        rst            = 1'b1;
        flush          = 1'b0;
        tx_active      = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = 8'h00;
        parity_type    = 2'b10;
        stop_bits      = 1'b0;
        data_length    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_frame", frame_out, 11'h7FF);
        check("rst_send", send, 0);
        check("rst_busy", busy, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_ready", wr_if.wr_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: 8-bit even parity, latency of send
        push(8'h55, 11'h4AA);
        repeat (3) @(negedge clk);
        check("t1_lat_pre", send, 0);
        @(negedge clk);
        check("t1_lat_send", send, 1);
        wait_send("t1");
        ack("t1", 1'b0);
        $display("t1 done: compared=%0d mismatched=%0d", n_cmp, n_fail);

        // Test 2: 7-bit odd parity, 2 stop; bit 7 ignored
        parity_type = 2'b01;
        stop_bits   = 1'b1;
        data_length = 1'b0;
        push(8'h41, 11'h782);
        wait_send("t2a");
        ack("t2a", 1'b0);
        push(8'hC1, 11'h782);
        wait_send("t2b");
        ack("t2b", 1'b0);
        $display("t2 done: compared=%0d mismatched=%0d", n_cmp, n_fail);

        // Test 3: parity_type 11 means no parity
        parity_type = 2'b11;
        stop_bits   = 1'b0;
        data_length = 1'b1;
        push(8'hA5, 11'h74A);
        wait_send("t3");
        ack("t3", 1'b0);
        $display("t3 done: compared=%0d mismatched=%0d", n_cmp, n_fail);

        // Test 4: fill FIFO while serializer busy, then drain in order
        parity_type = 2'b01;
        tx_active   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'(i * 37 + 3);
            push(b, model(b, 1'b1, 2'b01));
        end
        check("t4_full", fifo_full, 1);
        check("t4_ready", wr_if.wr_ready, 0);
        check("t4_busy", busy, 0);
        push(8'hEE, model(8'hEE, 1'b1, 2'b01));
        check("t4_sbsize", sb.size(), 16);
        check("t4_full2", fifo_full, 1);
        tx_active = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wait_send($sformatf("t4_%0d", i));
            ack($sformatf("t4_%0d", i), 1'b0);
        end
        check("t4_empty", fifo_empty, 1);
        $display("t4 done: compared=%0d mismatched=%0d", n_cmp, n_fail);

        // Test 5: flush during WAIT of frame 1
        parity_type = 2'b10;
        data_length = 1'b0;
        push(8'h3A, model(8'h3A, 1'b0, 2'b10));
        push(8'h7F, model(8'h7F, 1'b0, 2'b10));
        push(8'h80, model(8'h80, 1'b0, 2'b10));
        wait_send("t5");
        ack("t5", 1'b1);
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (send === 1'b1) saw = 1'b1;
        end
        check("t5_nosend", saw, 0);
        check("t5_empty", fifo_empty, 1);
        check("t5_idle", busy, 0);
        $display("t5 done: compared=%0d mismatched=%0d", n_cmp, n_fail);

        // Test 6: reset while in REQ, then recovery
        data_length = 1'b1;
        stop_bits   = 1'b1;
        @(posedge clk);
        #1;
        push(8'h11, model(8'h11, 1'b1, 2'b10));
        push(8'h22, model(8'h22, 1'b1, 2'b10));
        wait_send("t6");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_send", send, 0);
        check("t6_busy", busy, 0);
        check("t6_frame", frame_out, 11'h7FF);
        check("t6_empty", fifo_empty, 1);
        rst = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        push(8'h3C, model(8'h3C, 1'b1, 2'b10));
        wait_send("t6r");
        ack("t6r", 1'b0);
        $display("t6 done: compared=%0d mismatched=%0d", n_cmp, n_fail);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
